// File: rtl/f1_light_seq.sv
// f1_light_seq: starting-light sequencer (fill, random hold, extinguish); optional reaction timer under F1_REACTION_EN
module f1_light_seq #(
  parameter int LAMPS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trigger,
  input  logic [7:1]       rnd,
  output logic             rnd_ack,
  output logic [LAMPS-1:0] data_out,
  output logic             done,
  output logic             busy
`ifdef F1_REACTION_EN
  ,
  input  logic             react,
  output logic [15:0]      react_time
`endif
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  state_t state, state_n;
  logic [LAMPS-1:0] data_n;
  logic [6:0] cnt, cnt_n;
  logic done_n, ack_n;
  // next-state and next-output decode
  always_comb begin
    state_n = state;
    data_n = data_out;
    cnt_n = cnt;
    done_n = 1'b0;
    ack_n = 1'b0;
    case (state)
      IDLE: if (trigger) begin
        state_n = FILL;
        data_n = {{(LAMPS-1){1'b0}}, 1'b1};
      end
      FILL: if (en) begin
        if (&data_out) begin
          state_n = HOLD;
          cnt_n = (rnd == 7'd0) ? 7'd1 : rnd;
          ack_n = 1'b1;
        end else data_n = {data_out[LAMPS-2:0], 1'b1};
      end
      HOLD: if (en) begin
        cnt_n = cnt - 7'd1;
        if (cnt == 7'd1) begin
          state_n = IDLE;
          data_n = '0;
          done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data_out <= '0;
      cnt <= '0;
      done <= 1'b0;
      rnd_ack <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      data_out <= data_n;
      cnt <= cnt_n;
      done <= done_n;
      rnd_ack <= ack_n;
      busy <= state_n != IDLE;
    end
  end
`ifdef F1_REACTION_EN
  logic [15:0] r_cnt;
  logic r_run, jump;
  // reaction timer: counts en ticks from lights-out until react, jump start latches all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
      jump <= 1'b0;
      react_time <= '0;
    end else if (state == IDLE && trigger) begin
      r_cnt <= '0;
      r_run <= 1'b0;
      jump <= 1'b0;
      react_time <= '0;
    end else if (busy && react) begin
      jump <= 1'b1;
      react_time <= 16'hFFFF;
    end else if (done_n && !jump) r_run <= 1'b1;
    else if (r_run && react) begin
      react_time <= r_cnt;
      r_run <= 1'b0;
    end else if (r_run && en && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_f1_light_seq.sv
// tb_f1_light_seq: scoreboard bench for the starting-light sequencer
module tb_f1_light_seq;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, trigger = 1'b0;
  logic [7:1] rnd = '0;
  logic rnd_ack, done, busy;
  logic [7:0] data_out;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [7:0] d;
    logic dn;
    logic ak;
    logic bs;
    logic [7:0] t;
  } ev_t;
  ev_t exp_q[$];

  f1_light_seq #(.LAMPS(8)) dut (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .rnd(rnd),
    .rnd_ack(rnd_ack), .data_out(data_out), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    cyc(3);
    en = 1'b1;
    cyc(1);
    en = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic dn, input logic ak, input logic bs, input int t);
    ev_t e;
    e.d = d; e.dn = dn; e.ak = ak; e.bs = bs; e.t = 8'(t);
    exp_q.push_back(e);
  endtask

  task automatic push_fill(input int first_ticks);
    logic [7:0] m;
    m = 8'h01;
    push(m, 1'b0, 1'b0, 1'b1, first_ticks);
    for (int i = 1; i < 8; i++) begin
      m = {m[6:0], 1'b1};
      push(m, 1'b0, 1'b0, 1'b1, 1);
    end
    push(8'hFF, 1'b0, 1'b1, 1'b1, 1);
  endtask

  task automatic run_seq(input logic [6:0] r, input bit glitch);
    int n;
    n = (r == 7'd0) ? 1 : int'(r);
    push_fill(0);
    push(8'h00, 1'b1, 1'b0, 1'b0, n);
    rnd = r;
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (glitch && i == 1) begin
        trigger = 1'b1;
        rnd = ~r;
        cyc(1);
        trigger = 1'b0;
        rnd = r;
      end
    end
    rnd = ~r;
    for (int i = 0; i < n; i++) tick();
    cyc(4);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  // monitor: every output change or pulse is one event, popped against the scoreboard
  initial begin
    ev_t a, e;
    logic [7:0] prev;
    int t;
    prev = 8'h00;
    t = 0;
    forever begin
      @(posedge clk);
      if (en && busy) t++;
      @(negedge clk);
      if (data_out != prev || done || rnd_ack) begin
        a.d = data_out; a.dn = done; a.ak = rnd_ack; a.bs = busy; a.t = 8'(t);
        t = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got d=%h done=%b ack=%b busy=%b ticks=%0d", a.d, a.dn, a.ak, a.bs, a.t);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL event got d=%h done=%b ack=%b busy=%b ticks=%0d want d=%h done=%b ack=%b busy=%b ticks=%0d",
                     a.d, a.dn, a.ak, a.bs, a.t, e.d, e.dn, e.ak, e.bs, e.t);
          end
        end
      end
      prev = data_out;
    end
  end

  initial begin
    cyc(2);
    chk("reset_data", data_out, 8'h00);
    chk("reset_done", {7'd0, done}, 8'h00);
    chk("reset_ack", {7'd0, rnd_ack}, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    cyc(2);
    run_seq(7'd5, 1'b0);
    run_seq(7'd0, 1'b0);
    run_seq(7'h7F, 1'b0);
    run_seq(7'd6, 1'b1);
    push_fill(0);
    push(8'h00, 1'b0, 1'b0, 1'b0, 3);
    rnd = 7'd9;
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_done", {7'd0, done}, 8'h00);
    chk("midrst_busy", {7'd0, busy}, 8'h00);
    cyc(2);
    run_seq(7'd2, 1'b0);
    push_fill(0);
    push(8'h00, 1'b1, 1'b0, 1'b0, 1);
    push_fill(0);
    push(8'h00, 1'b1, 1'b0, 1'b0, 3);
    rnd = 7'd1;
    trigger = 1'b1;
    cyc(1);
    for (int i = 0; i < 9; i++) tick();
    cyc(1);
    trigger = 1'b0;
    rnd = 7'd3;
    for (int i = 0; i < 11; i++) tick();
    cyc(4);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) cyc(1);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
